// File: rtl/jk_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jk_seq_if                                             |
// | Brief    : Command handshake bundle for jk_bank_sequencer        |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface jk_seq_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CW-1:0]    cmd_count;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_count,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : jk_bank_sequencer                                     |
// | Brief    : Applies one masked JK op to a flip-flop bank for N    |
// |            cycles, then pulses done. Define JK_SEQ_VERIFY_EN to  |
// |            add an expected-Q model and sticky err check.         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  jk_seq_if.slave               cmd,
  output logic      [WIDTH-1:0] j,
  output logic      [WIDTH-1:0] k,
  output logic                  busy,
  output logic                  done,
  input  wire logic [WIDTH-1:0] q_fb,
  output logic                  err
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_apply = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [CW-1:0] c_cnt_last = CW'(1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;

  // Decode the incoming op; the j/k registers then hold the latched command.
  always_comb begin
    w_j_nxt = '0;
    w_k_nxt = '0;
    case (cmd.cmd_op)
      2'b01:   w_k_nxt = cmd.cmd_mask;
      2'b10:   w_j_nxt = cmd.cmd_mask;
      2'b11: begin
        w_j_nxt = cmd.cmd_mask;
        w_k_nxt = cmd.cmd_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (cmd.cmd_valid) begin
            if (cmd.cmd_count == '0) begin
              r_state <= c_st_done;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_st_apply;
              r_cnt   <= cmd.cmd_count;
              r_j     <= w_j_nxt;
              r_k     <= w_k_nxt;
            end
          end
        end
        c_st_apply: begin
          r_cnt <= r_cnt - c_cnt_last;
          // Drive is removed on the same edge that completes the Nth cycle.
          if (r_cnt == c_cnt_last) begin
            r_state <= c_st_done;
            r_done  <= 1'b1;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
          r_j     <= '0;
          r_k     <= '0;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == c_st_idle);
  assign busy          = (r_state != c_st_idle);
  assign done          = r_done;
  assign j             = r_j;
  assign k             = r_k;

`ifdef JK_SEQ_VERIFY_EN
  logic [WIDTH-1:0] r_q_model;
  logic             r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_model <= '0;
      r_err     <= 1'b0;
    end else begin
      r_q_model <= (r_j & ~r_q_model) | (~r_k & r_q_model);
      if ((r_state == c_st_done) && (q_fb != r_q_model)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_q_fb;
  assign w_unused_q_fb = ^q_fb;
  assign err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// Directed bench for jk_bank_sequencer: command table plus reset and
// err corner sequences, with a behavioural JK bank on q_fb.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 4;
  localparam int CW    = 4;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] exp_j;
    logic [WIDTH-1:0] exp_k;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] bank_q;
  logic             force_zero;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [7];

  always #5 clk = ~clk;

  jk_seq_if #(.WIDTH(WIDTH), .CW(CW)) cmd_if ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .j     (j),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .q_fb  (q_fb),
    .err   (err)
  );

  // External JK bank, written per bit from the truth table.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({j[b], k[b]})
          2'b01:   bank_q[b] <= 1'b0;
          2'b10:   bank_q[b] <= 1'b1;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  assign q_fb = force_zero ? '0 : bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = v.op;
    cmd_if.cmd_mask  = v.mask;
    cmd_if.cmd_count = v.count;
    @(negedge clk);
    for (int c = 0; c < int'(v.count); c++) begin
      chk("apply_j", 32'(j), 32'(v.exp_j));
      chk("apply_k", 32'(k), 32'(v.exp_k));
      chk("apply_busy", 32'(busy), 32'd1);
      chk("apply_done", 32'(done), 32'd0);
      // A competing command during APPLY must be ignored.
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = ~v.op;
      cmd_if.cmd_mask  = ~v.mask;
      cmd_if.cmd_count = 4'd1;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("done_j", 32'(j), 32'd0);
    chk("done_k", 32'(k), 32'd0);
    @(negedge clk);
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("bank_q", 32'(bank_q), 32'(v.exp_q));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic exp_err;
`ifdef JK_SEQ_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    //            op     mask     cnt    exp_j    exp_k    exp_q
    vecs[0] = '{2'b10, 4'b0101, 4'd1,  4'b0101, 4'b0000, 4'b0101};
    vecs[1] = '{2'b11, 4'b1111, 4'd3,  4'b1111, 4'b1111, 4'b1010};
    vecs[2] = '{2'b01, 4'b0010, 4'd0,  4'b0000, 4'b0000, 4'b1010};
    vecs[3] = '{2'b01, 4'b1000, 4'd2,  4'b0000, 4'b1000, 4'b0010};
    vecs[4] = '{2'b00, 4'b1111, 4'd2,  4'b0000, 4'b0000, 4'b0010};
    vecs[5] = '{2'b11, 4'b0011, 4'd15, 4'b0011, 4'b0011, 4'b0001};
    vecs[6] = '{2'b10, 4'b1100, 4'd4,  4'b1100, 4'b0000, 4'b1101};

    force_zero       = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_mask  = '0;
    cmd_if.cmd_count = '0;
    reset            = 1'b1;
    #12;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bank_q", 32'(bank_q), 32'd0);

    // Idle with no valid: nothing moves.
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_j", 32'(j), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end
    chk("err_clean_run", 32'(err), 32'd0);

    // Reset in the second APPLY cycle of TOGGLE count 5.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b11;
    cmd_if.cmd_mask  = 4'b1111;
    cmd_if.cmd_count = 4'd5;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("rstmid_apply1_j", 32'(j), 32'hF);
    @(negedge clk);
    chk("rstmid_apply2_k", 32'(k), 32'hF);
    reset = 1'b1;
    #1;
    chk("rstmid_j", 32'(j), 32'd0);
    chk("rstmid_k", 32'(k), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rstmid_no_done", 32'(done), 32'd0);
      chk("rstmid_ready", 32'(cmd_if.cmd_ready), 32'd1);
      chk("rstmid_busy_after", 32'(busy), 32'd0);
    end
    chk("rstmid_bank_q", 32'(bank_q), 32'd0);

    // Feedback stuck at zero after SET mask 1000 count 1.
    force_zero = 1'b1;
    v = '{2'b10, 4'b1000, 4'd1, 4'b1000, 4'b0000, 4'b1000};
    run_vec(v);
    chk("err_after_done", 32'(err), 32'(exp_err));
    force_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
